// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, the PC step, word alignment and the queued-entry layout
// for the instruction fetch stage.
package fetch_pkg;

  localparam int                WORD_W  = 32;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

  // One buffered fetch result: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

  // Clears the byte-offset bits so the PC addresses a whole instruction word.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a synchronous flush and an occupancy count.
// Writes to a full FIFO and reads from an empty FIFO are ignored; flush wins over
// any write or read in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_wr, do_rd;

  assign do_wr     = wr_en_i & (count_q != FULL_CNT);
  assign do_rd     = rd_en_i & (count_q != '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Next pointer/count values; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: prefetching fetch stage. Owns the fetch PC, issues word requests
// to a variable-latency in-order instruction memory, buffers responses in order and
// hands them to the core over valid/ready. A redirect flushes buffered entries and
// drops every response still owed for requests issued before it.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [WORD_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [WORD_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_pc_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] instr_pc_o,
  output logic [WORD_W-1:0] instr_pcp4_o
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_W = DEPTH[CNT_W:0];
  localparam int                ENTRY_W = $bits(fetch_entry_t);

  logic [WORD_W-1:0] fetch_pc_q,  fetch_pc_d;
  logic [CNT_W-1:0]  in_flight_q, in_flight_d;
  logic [CNT_W-1:0]  discard_q,   discard_d;

  logic [CNT_W-1:0]  fifo_count, tag_count;
  logic [CNT_W:0]    occupancy;
  logic [WORD_W-1:0] tag_pc;
  fetch_entry_t      wr_entry, head;
  logic              req_hs, rsp_ok, rsp_keep, pop;

  // Credit: buffered entries plus outstanding requests (stale ones included) never exceed DEPTH.
  assign occupancy   = {1'b0, fifo_count} + {1'b0, in_flight_q};
  assign imem_req_o  = rst_i & (occupancy < DEPTH_W) & ~redirect_i;
  assign imem_addr_o = fetch_pc_q;
  assign req_hs      = imem_req_o & imem_gnt_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok   = imem_rvalid_i & (in_flight_q != '0);
  assign rsp_keep = rsp_ok & (discard_q == '0) & (tag_count != '0);

  assign instr_valid_o = fifo_count != '0;
  assign pop           = instr_valid_o & instr_ready_i;
  assign wr_entry      = '{instr: imem_rdata_i, pc: tag_pc};

  // Head outputs read as zero while the queue is empty.
  assign instr_o      = instr_valid_o ? head.instr          : '0;
  assign instr_pc_o   = instr_valid_o ? head.pc             : '0;
  assign instr_pcp4_o = instr_valid_o ? (head.pc + PC_STEP) : '0;

  // PCs of issued requests, popped as their (non-discarded) responses return.
  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (redirect_i),
    .wr_en_i   (req_hs),
    .wr_data_i (fetch_pc_q),
    .rd_en_i   (rsp_keep),
    .rd_data_o (tag_pc),
    .count_o   (tag_count)
  );

  // Returned instructions waiting for the core.
  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_instr_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (redirect_i),
    .wr_en_i   (rsp_keep),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (fifo_count)
  );

  // Next fetch PC, outstanding-request count and stale-response count.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    in_flight_d = in_flight_q;
    discard_d   = discard_q;
    if (req_hs) in_flight_d = in_flight_d + 1'b1;
    if (rsp_ok) in_flight_d = in_flight_d - 1'b1;
    if (redirect_i) begin
      // Everything still outstanding after this cycle's response belongs to the old path.
      fetch_pc_d = align_word(redirect_pc_i);
      discard_d  = in_flight_d;
    end else begin
      if (req_hs) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_ok && (discard_q != '0)) discard_d = discard_q - 1'b1;
    end
  end

  // Fetch-control state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q  <= align_word(RESET_PC);
      in_flight_q <= '0;
      discard_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
    end
  end

  // The memory must never return a response that was not requested.
  a_rvalid_has_request: assert property (
    @(posedge clk_i) disable iff (!rst_i) imem_rvalid_i |-> (in_flight_q != '0)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: randomized bench with an in-order memory model, a queue-based
// reference of the fetch stream and a scoreboard monitor on the core-side handshake.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o, instr_pc_o, instr_pcp4_o;

  always #5 clk_i = ~clk_i;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_pcp4_o  (instr_pcp4_o)
  );

  // ---------------- reference state ----------------
  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } req_t;

  req_t         outst[$];     // requests accepted by memory, oldest first
  fetch_entry_t exp_q[$];     // entries the core should see, oldest first
  logic [31:0]  model_pc = RESET_PC;
  logic [31:0]  popped_pc[$];
  int cyc = 0, hs_count = 0, pop_count = 0, stale_drops = 0;
  int n_checks = 0, n_errors = 0;

  int gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1, redir_permille = 0;

  function automatic logic [31:0] instr_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs; called right after a falling edge.
  task automatic drive_inputs(input bit redir, input logic [31:0] tgt);
    if (rst_i && outst.size() > 0 && outst[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = instr_word(outst[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    instr_ready_i = ($urandom_range(99) < ready_pct);
    redirect_i    = redir || ($urandom_range(999) < redir_permille);
    redirect_pc_i = redir ? tgt : $urandom;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk_i);
      drive_inputs(1'b0, '0);
    end
  endtask

  task automatic assert_reset();
    @(negedge clk_i);
    rst_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0;
    imem_gnt_i = 1'b0; instr_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    drive_inputs(1'b0, '0);
  endtask

  // Memory/fetch model: retires this cycle's response, records this cycle's
  // request, then applies a redirect. Runs late in the cycle, before the rising edge.
  req_t r;
  initial forever begin
    @(negedge clk_i); #4;
    if (!rst_i) begin
      outst.delete(); exp_q.delete(); model_pc = RESET_PC;
    end else begin
      if (imem_rvalid_i && outst.size() > 0) begin
        r = outst.pop_front();
        if (r.stale) stale_drops++;
        else exp_q.push_back('{instr: instr_word(r.addr), pc: r.addr});
      end
      if (imem_req_o && imem_gnt_i) begin
        check("req_addr", imem_addr_o, model_pc);
        outst.push_back('{addr: model_pc, stale: 1'b0, due: cyc + $urandom_range(lat_max, lat_min)});
        model_pc = model_pc + 32'd4;
        hs_count++;
      end
      if (redirect_i) begin
        exp_q.delete();
        foreach (outst[i]) outst[i].stale = 1'b1;
        model_pc = {redirect_pc_i[31:2], 2'b00};
      end
    end
    cyc++;
  end

  // Scoreboard monitor: request gating, head validity and every consumed entry.
  fetch_entry_t e;
  bit exp_req;
  initial forever begin
    @(negedge clk_i); #2;
    if (rst_i) begin
      exp_req = ((exp_q.size() + outst.size()) < DEPTH) && !redirect_i;
      check("imem_req", imem_req_o, exp_req);
      check("instr_valid", instr_valid_o, exp_q.size() != 0);
      if (instr_valid_o && instr_ready_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("instr", instr_o, e.instr);
        check("instr_pc", instr_pc_o, e.pc);
        check("instr_pcp4", instr_pcp4_o, e.pc + 32'd4);
        popped_pc.push_back(instr_pc_o);
        pop_count++;
      end
    end
  end

  // Global time bound.
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  int  h0, p0, s0;
  bit  found;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_req", imem_req_o, 1'b0);
    check("rst_valid", instr_valid_o, 1'b0);
    check("rst_instr", instr_o, '0);
    check("rst_pc", instr_pc_o, '0);
    check("rst_pcp4", instr_pcp4_o, '0);
    check("rst_addr", imem_addr_o, RESET_PC);

    // Streaming: latency 1, always granted, always ready.
    release_reset();
    @(negedge clk_i); drive_inputs(1'b0, '0); #1;
    check("stream_valid_c1", instr_valid_o, 1'b0);
    @(negedge clk_i); drive_inputs(1'b0, '0); #1;
    check("stream_valid_c2", instr_valid_o, 1'b1);
    check("stream_pc_c2", instr_pc_o, RESET_PC);
    run_cycles(25);

    // Asynchronous reset between clock edges.
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    check("async_rst_req", imem_req_o, 1'b0);
    check("async_rst_valid", instr_valid_o, 1'b0);
    @(negedge clk_i); imem_rvalid_i = 1'b0; redirect_i = 1'b0;
    @(negedge clk_i);
    release_reset(); #1;
    check("restart_addr", imem_addr_o, RESET_PC);
    run_cycles(10);

    // Backpressure from a clean start.
    assert_reset();
    ready_pct = 0;
    h0 = hs_count;
    release_reset();
    run_cycles(12);
    #1;
    check("bp_requests", hs_count - h0, DEPTH);
    check("bp_req_low", imem_req_o, 1'b0);
    popped_pc.delete();
    ready_pct = 100;
    run_cycles(10);
    for (int i = 0; i < DEPTH; i++)
      check("bp_order", (i < popped_pc.size()) ? popped_pc[i] : 32'hDEAD_DEAD, RESET_PC + 32'(4 * i));

    // Redirect with two requests in flight, latency 3.
    assert_reset();
    lat_min = 3; lat_max = 3;
    release_reset();
    s0 = stale_drops;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_i);
      if (outst.size() == 2) begin
        drive_inputs(1'b1, 32'h0000_0103);
        found = 1'b1;
      end else drive_inputs(1'b0, '0);
    end
    check("redir_inflight_seen", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i); drive_inputs(1'b0, '0); #1;
      if (instr_valid_o) begin
        check("redir_first_pc", instr_pc_o, 32'h0000_0100);
        found = 1'b1;
      end
    end
    check("redir_first_valid", found, 1'b1);
    check("redir_dropped", stale_drops - s0, 2);

    // Redirect and pop in the same cycle.
    assert_reset();
    lat_min = 1; lat_max = 1;
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_i);
      if (instr_valid_o) begin
        p0 = pop_count;
        drive_inputs(1'b1, 32'h0000_0200);
        #1;
        check("redir_pop_no_req", imem_req_o, 1'b0);
        found = 1'b1;
      end else drive_inputs(1'b0, '0);
    end
    @(negedge clk_i); drive_inputs(1'b0, '0); #1;
    check("redir_pop_valid_next", instr_valid_o, 1'b0);
    check("redir_pop_consumed", pop_count - p0, 1);
    run_cycles(8);

    // Wrap at the top of the address space.
    assert_reset();
    release_reset();
    @(negedge clk_i); drive_inputs(1'b1, 32'hFFFF_FFFA);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i); drive_inputs(1'b0, '0); #1;
      if (instr_valid_o && instr_pc_o == 32'hFFFF_FFFC) begin
        check("wrap_pcp4", instr_pcp4_o, 32'h0000_0000);
        found = 1'b1;
      end
    end
    check("wrap_seen", found, 1'b1);
    run_cycles(6);

    // Randomized traffic.
    gnt_pct = 70; ready_pct = 60; lat_min = 1; lat_max = 4; redir_permille = 40;
    run_cycles(3000);

    // Drain: stop issuing, let everything owed come out.
    gnt_pct = 0; ready_pct = 100; redir_permille = 0;
    run_cycles(30);
    #1;
    check("drain_outstanding", outst.size(), 0);
    check("drain_expected", exp_q.size(), 0);
    check("drain_valid", instr_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Prefetching instruction fetch stage that sits directly upstream of the CPU decode/execute datapath.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory.
- Buffers returned instructions in order in a small FIFO and presents them to the core with a valid/ready handshake.
- On a branch/jump redirect from the core, flushes queued and in-flight fetches and restarts at the new PC.

Parameters:
- DEPTH, 4, FIFO entries; also caps queued + in-flight requests. Power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch word address; bits [1:0] are always 0.
- imem_gnt_i  in  1  request accepted this cycle (handshake is imem_req_o & imem_gnt_i).
- imem_rvalid_i  in  1  response valid. Responses are in order, one per accepted request, latency ≥1 cycle.
- imem_rdata_i  in  32  response instruction word.
- redirect_i  in  1  core takes a branch/jump/jr this cycle.
- redirect_pc_i  in  32  target PC; bits [1:0] are ignored and forced to 0.
- instr_valid_o  out  1  head entry valid.
- instr_ready_i  in  1  core consumes the head this cycle.
- instr_o  out  32  head instruction word.
- instr_pc_o  out  32  head PC.
- instr_pcp4_o  out  32  head PC+4, used as the jal link value and branch base.

Behaviour:
- Reset state (async, rst_i=0):
  - fetch_pc = RESET_PC.
  - FIFO count = 0.
  - in_flight = 0.
  - discard = 0.
  - All outputs are 0: imem_req_o=0, instr_valid_o=0, instr_o/instr_pc_o/instr_pcp4_o=0, imem_addr_o=RESET_PC.
- Issue:
  - imem_req_o = (count + in_flight < DEPTH) & ~redirect_i.
  - imem_addr_o = fetch_pc.
  - On handshake: fetch_pc += 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), in_flight += 1.
  - The PC of each request is pushed into an internal tag queue (depth DEPTH).
- Response:
  - On imem_rvalid_i, in_flight -= 1.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise, write {rdata, tag PC} into the FIFO.
  - No bypass: instr_valid_o rises in the cycle after rvalid. Minimum request-to-valid latency is 2 cycles.
- Dequeue:
  - instr_valid_o = (count != 0).
  - A pop occurs on instr_valid_o & instr_ready_i.
  - Simultaneous pop and write: count is unchanged, and order is preserved.
- Redirect (cycle t):
  - The pop in cycle t completes normally.
  - FIFO is flushed; count = 0 at t+1.
  - discard = in_flight after accounting for any rvalid in cycle t.
  - fetch_pc = {redirect_pc_i[31:2], 2'b00}.
  - No request is issued in cycle t.
  - A new request to the target may issue at t+1 if credit allows.
  - instr_valid_o = 0 at t+1.
- Redirect arriving while discard > 0: discard accumulates, and stale responses continue to be dropped.
- Full: when count + in_flight == DEPTH, imem_req_o = 0. The counters can never exceed DEPTH.
- Empty: instr_valid_o = 0, and instr_ready_i is ignored.
- An rvalid with in_flight == 0 is a protocol error. It is asserted in simulation and ignored in RTL.
- Reset asserted mid-operation: all state clears immediately. Responses arriving after reset are treated as protocol errors.

Decomposition:
- Package fetch_pkg holds:
  - WORD_W = 32.
  - PC_STEP = 4.
  - Function align_word(pc).
  - Typedef fetch_entry_t {instr[31:0], pc[31:0]}.
- Sub-module sync_fifo (parameterised width/depth, with flush input, count output, async active-low reset).
  - Instantiated twice: once for the tag queue and once for the instruction FIFO.

Test Plan:
- Streaming:
  - Stimulus: release reset, imem latency 1, gnt=1 always, ready=1.
  - Required response: addresses 0, 4, 8, … issue on consecutive cycles. instr_pc_o is 0 at cycle 2, then one instruction per cycle. instr_pcp4_o = instr_pc_o + 4.
- Backpressure:
  - Stimulus: ready=0 with DEPTH=4.
  - Required response: exactly 4 requests issue (0x0–0xC), then imem_req_o stays 0. After ready=1, entries pop in order 0x0, 0x4, 0x8, 0xC.
- Redirect with in-flight requests:
  - Stimulus: latency 3; redirect_pc_i=0x103 asserted while 2 requests are in flight.
  - Required response: the 2 stale responses are dropped. The next request address is 0x100. The first valid output has instr_pc_o=0x100.
- Redirect plus pop in the same cycle:
  - Stimulus: redirect and a pop in the same cycle.
  - Required response: the head is consumed, instr_valid_o=0 next cycle, and no request issues in the redirect cycle.
- Wrap:
  - Stimulus: RESET_PC=32'hFFFF_FFF8.
  - Required response: request addresses are FFFF_FFF8, FFFF_FFFC, 0000_0000. For the FFFF_FFFC entry, instr_pcp4_o=0.
- Async reset:
  - Stimulus: rst_i=0 mid-stream, between clock edges.
  - Required response: instr_valid_o and imem_req_o drop immediately. After release, fetch restarts at RESET_PC.
